// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dm_pkg
//  Purpose : Shared types and constants for the data-memory responder:
//            FSM state encoding and wait-counter width.
//  Rev     : 1.0  initial release
// ============================================================================
package dm_pkg;

    // Width of the wait-state counter; covers LATENCY up to 15.
    localparam int DM_CNT_W = 4;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_t;

endpackage : dm_pkg
`default_nettype wire

// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
//  Module  : dm_responder_if
//  Purpose : M-stage data-memory request/response bundle.
//  Signals : req, we, addr[31:0], be[3:0], wdata[31:0], pc[31:0]  (requester)
//            rdata[31:0], resp_valid, busy                          (responder)
//  Modports: master = requester side, slave = responder side
//  Rev     : 1.0  initial release
// ============================================================================
interface dm_responder_if;
    import dm_pkg::*;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        busy;

    modport master (
        output req, we, addr, be, wdata, pc,
        input  rdata, resp_valid, busy
    );

    modport slave (
        input  req, we, addr, be, wdata, pc,
        output rdata, resp_valid, busy
    );

endinterface : dm_responder_if
`default_nettype wire

// File: rtl/dm_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module  : dm_byte_merge
//  Purpose : Combinational byte-lane merge for stores. Lane i of the result
//            takes wdata when be[i] is set, otherwise keeps the old word.
//  Ports   : i_old[31:0]    current memory word
//            i_wdata[31:0]  lane-aligned store data
//            i_be[3:0]      byte enables
//            o_merged[31:0] merged word
//  Rev     : 1.0  initial release
// ============================================================================
module dm_byte_merge
    import dm_pkg::*;
(
    input  wire logic [31:0] i_old,
    input  wire logic [31:0] i_wdata,
    input  wire logic [3:0]  i_be,
    output logic      [31:0] o_merged
);

    generate
        for (genvar g = 0; g < 4; g++) begin : g_lane
            assign o_merged[8*g +: 8] = i_be[g] ? i_wdata[8*g +: 8] : i_old[8*g +: 8];
        end
    endgenerate

endmodule : dm_byte_merge
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module  : dm_responder
//  Purpose : Data-memory responder for the CPU M stage. Accepts one load/store
//            at a time, inserts LATENCY wait states, merges stores per byte
//            lane, pulses resp_valid once per request and drives busy to the
//            hazard controller.
//  Params  : ADDR_WIDTH  word-index width (2**ADDR_WIDTH 32-bit words)
//            LATENCY     wait states between acceptance and response (0..15)
//  Ports   : clk, reset (synchronous, active-high)
//            bus         dm_responder_if.slave (request in, response out)
//  Config  : DM_WRITE_LOG_EN  when defined, prints a line for every in-range
//            store commit; no effect on cycle behaviour.
//  Rev     : 1.0  initial release
// ============================================================================
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dm_responder_if.slave bus
);

    localparam int c_depth = 2 ** ADDR_WIDTH;
    localparam logic [DM_CNT_W-1:0] c_lat_m1 =
        (LATENCY == 0) ? '0 : DM_CNT_W'(LATENCY - 1);

    dm_state_t            r_state;
    dm_state_t            w_state_nxt;
    logic [DM_CNT_W-1:0]  r_cnt;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [3:0]           r_be;
    logic [31:0]          r_wdata;
    logic [31:0]          r_pc;
    logic [31:0]          r_rdata;
    logic [31:0]          r_mem [c_depth];

    // With LATENCY==0 the commit happens on the very edge that accepts the
    // request, so the live bus values are used while in IDLE and the latched
    // copies everywhere else.
    logic                  w_idle;
    logic                  w_we;
    logic [31:0]           w_addr;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_pc;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_commit;

    assign w_idle     = (r_state == DM_IDLE);
    assign w_we       = w_idle ? bus.we    : r_we;
    assign w_addr     = w_idle ? bus.addr  : r_addr;
    assign w_be       = w_idle ? bus.be    : r_be;
    assign w_wdata    = w_idle ? bus.wdata : r_wdata;
    assign w_pc       = w_idle ? bus.pc    : r_pc;
    assign w_idx      = w_addr[ADDR_WIDTH+1:2];
    assign w_in_range = (w_addr[31:ADDR_WIDTH+2] == '0);
    assign w_old      = r_mem[w_idx];
    assign w_commit   = (w_state_nxt == DM_RESP) && (r_state != DM_RESP);

    dm_byte_merge u_merge (
        .i_old    (w_old),
        .i_wdata  (w_wdata),
        .i_be     (w_be),
        .o_merged (w_merged)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        w_state_nxt    = r_state;
        bus.busy       = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            DM_IDLE: begin
                bus.busy = bus.req;
                if (bus.req) begin
                    w_state_nxt = (LATENCY == 0) ? DM_RESP : DM_WAIT;
                end
            end
            DM_WAIT: begin
                bus.busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = DM_RESP;
                end
            end
            DM_RESP: begin
                // Held req is ignored here; the pipeline advances at the end of RESP.
                bus.resp_valid = 1'b1;
                w_state_nxt    = DM_IDLE;
            end
            default: begin
                w_state_nxt = DM_IDLE;
            end
        endcase
    end

    // ---------------- Datapath: latches, counter, memory, rdata ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
            r_rdata <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_idle && bus.req) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_be    <= bus.be;
                r_wdata <= bus.wdata;
                r_pc    <= bus.pc;
                r_cnt   <= c_lat_m1;
            end else if ((r_state == DM_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_commit) begin
                if (!w_in_range) begin
                    // Out-of-range: store dropped, nothing to return.
                    r_rdata <= '0;
                end else if (w_we) begin
                    r_mem[w_idx] <= w_merged;
                    r_rdata      <= w_merged;
`ifdef DM_WRITE_LOG_EN
                    $display("%d@%h: *%h <= %h", $time, w_pc, {w_addr[31:2], 2'b00}, w_merged);
`endif
                end else begin
                    r_rdata <= w_old;
                end
            end
        end
    end

    assign bus.rdata = r_rdata;

    // Byte-offset bits never select anything; pc only feeds the write log.
    logic w_unused_ok;
`ifdef DM_WRITE_LOG_EN
    assign w_unused_ok = ^w_addr[1:0];
`else
    assign w_unused_ok = ^{w_addr[1:0], w_pc};
`endif

endmodule : dm_responder
`default_nettype wire
